tr_stack_cache: RTL and testbench

Parametrised top-of-stack register cache for the stack-machine datapath. It holds the top DEPTH data-stack entries in registers, with entry 0 driven out as TR and entry 1 as NOS. It selects a new top value from NSRC source buses and performs LOAD/PUSH/POP/SWAP. Overflowing entries spill to the data-stack memory, and underflowing pops refill from it, over valid/ready handshakes.

---
 rtl/tr_stack_cache_if.sv | 40 ++++
 rtl/tr_stack_cache.sv | 143 ++++++++++++++
 tb/tb_tr_stack_cache.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/tr_stack_cache_if.sv
// Bundle of operation, stack-view and memory spill/fill signals for tr_stack_cache.
interface tr_stack_cache_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned NSRC      = 8,
    parameter int unsigned MEM_DEPTH = 256
) ();
    localparam int unsigned SelW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned MemW = $clog2(MEM_DEPTH + 1);

    logic [NSRC*WIDTH-1:0] src_data;
    logic [SelW-1:0]       tr_src;
    logic [1:0]            op;
    logic                  op_valid;
    logic                  op_ready;
    logic [WIDTH-1:0]      TR;
    logic [WIDTH-1:0]      NOS;
    logic [CntW-1:0]       count;
    logic [MemW-1:0]       mem_cnt;
    logic                  spill_valid;
    logic [WIDTH-1:0]      spill_data;
    logic                  spill_ready;
    logic                  fill_req;
    logic [WIDTH-1:0]      fill_data;
    logic                  fill_valid;
    logic                  err;

    // Requester / memory side
    modport master (
        output src_data, tr_src, op, op_valid, spill_ready, fill_data, fill_valid,
        input  op_ready, TR, NOS, count, mem_cnt, spill_valid, spill_data, fill_req, err
    );

    // Stack cache side
    modport slave (
        input  src_data, tr_src, op, op_valid, spill_ready, fill_data, fill_valid,
        output op_ready, TR, NOS, count, mem_cnt, spill_valid, spill_data, fill_req, err
    );
endinterface

// File: rtl/tr_stack_cache.sv
// Top-of-stack register cache: DEPTH entries in registers, spill/refill to backing memory.
module tr_stack_cache #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned NSRC      = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input logic             CLK,
    input logic             reset,
    tr_stack_cache_if.slave bus
);
    localparam int unsigned SelW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned MemW = $clog2(MEM_DEPTH + 1);

    localparam logic [1:0] OpLoad = 2'd0;
    localparam logic [1:0] OpPush = 2'd1;
    localparam logic [1:0] OpPop  = 2'd2;
    localparam logic [1:0] OpSwap = 2'd3;

    typedef enum logic [1:0] {StIdle, StSpill, StFill} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];
    logic [CntW-1:0]  count_q, count_d;
    logic [MemW-1:0]  mem_cnt_q, mem_cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] push_q, push_d;
    logic [WIDTH-1:0] src_sel;

    // Source mux; selects outside 0..NSRC-1 yield zero
    always_comb begin
        src_sel = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.tr_src == SelW'(k)) src_sel = bus.src_data[k*WIDTH +: WIDTH];
        end
    end

    // Next-state logic for the FSM and the stack entries
    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        count_d   = count_q;
        mem_cnt_d = mem_cnt_q;
        err_d     = err_q;
        push_d    = push_q;
        unique case (state_q)
            StIdle: begin
                if (bus.op_valid) begin
                    case (bus.op)
                        OpLoad: begin
                            entry_d[0] = src_sel;
                            if (count_q == '0) count_d = CntW'(1);
                        end
                        OpPush: begin
                            if (count_q < CntW'(DEPTH)) begin
                                for (int i = 1; i < DEPTH; i++) entry_d[i] = entry_q[i-1];
                                entry_d[0] = src_sel;
                                count_d    = count_q + CntW'(1);
                            end else if (mem_cnt_q < MemW'(MEM_DEPTH)) begin
                                // Bottom entry must reach memory before the shift
                                push_d  = src_sel;
                                state_d = StSpill;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OpPop: begin
                            if (count_q >= CntW'(2)) begin
                                for (int i = 0; i < DEPTH - 1; i++) entry_d[i] = entry_q[i+1];
                                entry_d[DEPTH-1] = '0;
                                count_d          = count_q - CntW'(1);
                            end else if (count_q == CntW'(1)) begin
                                if (mem_cnt_q != '0) begin
                                    state_d = StFill;
                                end else begin
                                    entry_d[0] = '0;
                                    count_d    = '0;
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            if (count_q >= CntW'(2)) begin
                                entry_d[0] = entry_q[1];
                                entry_d[1] = entry_q[0];
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            StSpill: begin
                if (bus.spill_ready) begin
                    for (int i = 1; i < DEPTH; i++) entry_d[i] = entry_q[i-1];
                    entry_d[0] = push_q;
                    mem_cnt_d  = mem_cnt_q + MemW'(1);
                    state_d    = StIdle;
                end
            end
            StFill: begin
                if (bus.fill_valid) begin
                    entry_d[0] = bus.fill_data;
                    mem_cnt_d  = mem_cnt_q - MemW'(1);
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any transfer in flight
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            mem_cnt_q <= '0;
            err_q     <= 1'b0;
            push_q    <= '0;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mem_cnt_q <= mem_cnt_d;
            err_q     <= err_d;
            push_q    <= push_d;
            entry_q   <= entry_d;
        end
    end

    assign bus.op_ready    = (state_q == StIdle);
    assign bus.spill_valid = (state_q == StSpill);
    assign bus.fill_req    = (state_q == StFill);
    assign bus.spill_data  = entry_q[DEPTH-1];
    assign bus.TR          = entry_q[0];
    assign bus.NOS         = entry_q[1];
    assign bus.count       = count_q;
    assign bus.mem_cnt     = mem_cnt_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_tr_stack_cache.sv
// Directed bench for tr_stack_cache with hand-computed expectations.
module tb_tr_stack_cache;
    localparam int unsigned WIDTH     = 16;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned NSRC      = 8;
    localparam int unsigned MEM_DEPTH = 256;

    localparam logic [1:0] OpLoad = 2'd0;
    localparam logic [1:0] OpPush = 2'd1;
    localparam logic [1:0] OpPop  = 2'd2;
    localparam logic [1:0] OpSwap = 2'd3;

    logic CLK;
    logic reset;
    int   checks;
    int   failures;

    tr_stack_cache_if #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NSRC(NSRC), .MEM_DEPTH(MEM_DEPTH)
    ) bus ();

    tr_stack_cache #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NSRC(NSRC), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int k, input logic [WIDTH-1:0] v);
        bus.src_data[k*WIDTH +: WIDTH] = v;
    endtask

    // Present one op for a single cycle; returns 1 time unit after the accepting edge
    task automatic do_op(input logic [1:0] o, input logic [2:0] s);
        @(negedge CLK);
        bus.op       = o;
        bus.tr_src   = s;
        bus.op_valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.op_valid = 1'b0;
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        bus.src_data     = '0;
        bus.tr_src       = '0;
        bus.op           = OpLoad;
        bus.op_valid     = 1'b0;
        bus.spill_ready  = 1'b0;
        bus.fill_data    = '0;
        bus.fill_valid   = 1'b0;
        reset            = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
        #1;

        check("rst_tr", bus.TR, 0);
        check("rst_nos", bus.NOS, 0);
        check("rst_count", bus.count, 0);
        check("rst_mem_cnt", bus.mem_cnt, 0);
        check("rst_err", bus.err, 0);
        check("rst_op_ready", bus.op_ready, 1);
        check("rst_spill_valid", bus.spill_valid, 0);
        check("rst_fill_req", bus.fill_req, 0);

        // Four pushes fill the cache
        for (int v = 1; v <= 4; v++) begin
            set_src(3, 16'(v));
            do_op(OpPush, 3'd3);
        end
        check("push4_tr", bus.TR, 16'h0004);
        check("push4_nos", bus.NOS, 16'h0003);
        check("push4_count", bus.count, 4);

        // Fifth push spills entry 3 (value 1), memory stalls for 3 cycles
        set_src(3, 16'h0005);
        do_op(OpPush, 3'd3);
        for (int c = 0; c < 3; c++) begin
            check("spill_valid", bus.spill_valid, 1);
            check("spill_data", bus.spill_data, 16'h0001);
            check("spill_op_ready", bus.op_ready, 0);
            check("spill_tr_held", bus.TR, 16'h0004);
            if (c < 2) begin
                @(posedge CLK);
                #1;
            end
        end
        bus.spill_ready = 1'b1;
        @(posedge CLK);
        #1;
        bus.spill_ready = 1'b0;
        check("spill_done_tr", bus.TR, 16'h0005);
        check("spill_done_nos", bus.NOS, 16'h0004);
        check("spill_done_mem", bus.mem_cnt, 1);
        check("spill_done_count", bus.count, 4);
        check("spill_done_valid", bus.spill_valid, 0);
        check("spill_done_ready", bus.op_ready, 1);

        // Cache holds 5,4,3,2: three pops leave only 2
        for (int p = 0; p < 3; p++) do_op(OpPop, 3'd0);
        check("pop3_count", bus.count, 1);
        check("pop3_tr", bus.TR, 16'h0002);
        check("pop3_nos", bus.NOS, 16'h0000);

        // Next pop must refill from memory
        do_op(OpPop, 3'd0);
        check("fill_req", bus.fill_req, 1);
        check("fill_op_ready", bus.op_ready, 0);
        @(posedge CLK);
        #1;
        check("fill_wait_tr", bus.TR, 16'h0002);
        bus.fill_data  = 16'h0001;
        bus.fill_valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.fill_valid = 1'b0;
        check("fill_tr", bus.TR, 16'h0001);
        check("fill_mem", bus.mem_cnt, 0);
        check("fill_count", bus.count, 1);
        check("fill_req_off", bus.fill_req, 0);

        // LOAD keeps count, PUSH builds a pair, SWAP exchanges it
        set_src(2, 16'h0055);
        do_op(OpLoad, 3'd2);
        check("load_tr", bus.TR, 16'h0055);
        check("load_count", bus.count, 1);
        set_src(5, 16'h00AA);
        do_op(OpPush, 3'd5);
        do_op(OpSwap, 3'd0);
        check("swap_tr", bus.TR, 16'h0055);
        check("swap_nos", bus.NOS, 16'h00AA);
        check("swap_err", bus.err, 0);

        // Drain to empty: last pop with empty memory zeroes TR
        do_op(OpPop, 3'd0);
        check("pop_tr", bus.TR, 16'h00AA);
        check("pop_nos", bus.NOS, 16'h0000);
        do_op(OpPop, 3'd0);
        check("pop_empty_tr", bus.TR, 0);
        check("pop_empty_count", bus.count, 0);
        check("pop_empty_err", bus.err, 0);

        // Underflow
        do_op(OpPop, 3'd0);
        check("uflow_err", bus.err, 1);
        check("uflow_tr", bus.TR, 0);
        check("uflow_nos", bus.NOS, 0);
        check("uflow_count", bus.count, 0);
        check("uflow_mem", bus.mem_cnt, 0);
        check("uflow_ready", bus.op_ready, 1);

        // LOAD on empty stack sets count to 1; err is sticky
        set_src(6, 16'h1234);
        do_op(OpLoad, 3'd6);
        check("load_empty_tr", bus.TR, 16'h1234);
        check("load_empty_count", bus.count, 1);
        check("err_sticky", bus.err, 1);

        // Fill the cache again and abort a spill with reset
        for (int v = 0; v < 3; v++) begin
            set_src(1, 16'(16'h0100 + v));
            do_op(OpPush, 3'd1);
        end
        check("refill_count", bus.count, 4);
        set_src(1, 16'h0BAD);
        do_op(OpPush, 3'd1);
        check("spill2_valid", bus.spill_valid, 1);
        check("spill2_data", bus.spill_data, 16'h1234);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst_spill_valid", bus.spill_valid, 0);
        check("arst_op_ready", bus.op_ready, 1);
        check("arst_tr", bus.TR, 0);
        check("arst_count", bus.count, 0);
        check("arst_err", bus.err, 0);
        @(negedge CLK);
        reset = 1'b0;
        @(posedge CLK);
        #1;
        check("post_rst_spill", bus.spill_valid, 0);
        check("post_rst_tr", bus.TR, 0);
        check("post_rst_nos", bus.NOS, 0);
        check("post_rst_mem", bus.mem_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
